regfile_write_sched: RTL and testbench

//  Write-port scheduler for the ID-stage register file built from per-register

---
 rtl/regfile_write_sched_if.sv | 29 ++
 rtl/regfile_write_sched.sv | 87 ++++++++
 tb/tb_regfile_write_sched.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_sched_if.sv
// Write-request bus between the two requesters (writeback, debug) and the
// register-file write scheduler, plus the per-register write-enable fan-out.
interface regfile_write_sched_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
);
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             wb_ready;
    logic             dbg_valid;
    logic [AW-1:0]    dbg_addr;
    logic [XLEN-1:0]  dbg_data;
    logic             dbg_ready;
    logic             init_busy;
    logic [NREGS-1:0] rf_we;
    logic [XLEN-1:0]  rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
        input  wb_ready, dbg_ready, init_busy, rf_we, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
        output wb_ready, dbg_ready, init_busy, rf_we, rf_wdata
    );
endinterface

// File: rtl/regfile_write_sched.sv
// Single write-port scheduler: clears x1..x(NREGS-1) after reset, then
// round-robins writeback and debug writes onto one-hot enables + shared data.
module regfile_write_sched #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    regfile_write_sched_if.slave  s_bus
);
    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        r_state;
    logic [AW-1:0] r_init_idx;
    logic          r_rr_last;   // 0 = wb granted last, 1 = dbg granted last

    state_t        w_state_nxt;
    logic [AW-1:0] w_init_idx_nxt;
    logic          w_rr_last_nxt;
    logic          w_gnt_wb;
    logic          w_gnt_dbg;

    // x0 and out-of-range addresses decode to no enable at all
    function automatic logic [NREGS-1:0] f_onehot(input logic [AW-1:0] addr);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 1; i < NREGS; i++)
            if (addr == AW'(i)) v[i] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_INIT;
            r_init_idx <= AW'(1);
            r_rr_last  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_init_idx <= w_init_idx_nxt;
            r_rr_last  <= w_rr_last_nxt;
        end
    end

    always_comb begin
        w_gnt_wb  = s_bus.wb_valid  && (!s_bus.dbg_valid || r_rr_last);
        w_gnt_dbg = s_bus.dbg_valid && (!s_bus.wb_valid  || !r_rr_last);
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_init_idx_nxt  = r_init_idx;
        w_rr_last_nxt   = r_rr_last;
        s_bus.wb_ready  = 1'b0;
        s_bus.dbg_ready = 1'b0;
        s_bus.init_busy = 1'b0;
        s_bus.rf_we     = '0;
        s_bus.rf_wdata  = '0;
        if (i_reset) begin
            s_bus.init_busy = 1'b1;
        end else begin
            unique case (r_state)
                S_INIT: begin
                    s_bus.init_busy = 1'b1;
                    s_bus.rf_we     = f_onehot(r_init_idx);
                    w_init_idx_nxt  = r_init_idx + AW'(1);
                    if (r_init_idx == AW'(NREGS - 1))
                        w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (w_gnt_wb) begin
                        s_bus.wb_ready = 1'b1;
                        s_bus.rf_we    = f_onehot(s_bus.wb_addr);
                        s_bus.rf_wdata = s_bus.wb_data;
                        w_rr_last_nxt  = 1'b0;
                    end else if (w_gnt_dbg) begin
                        s_bus.dbg_ready = 1'b1;
                        s_bus.rf_we     = f_onehot(s_bus.dbg_addr);
                        s_bus.rf_wdata  = s_bus.dbg_data;
                        w_rr_last_nxt   = 1'b1;
                    end
                end
                default: w_state_nxt = S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_write_sched.sv
// Scoreboard bench for regfile_write_sched: stimulus queues expected write
// events, a negedge monitor pops and compares every cycle the DUT acts.
module tb_regfile_write_sched;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    typedef struct packed {
        logic [NREGS-1:0] we;
        logic [XLEN-1:0]  wdata;
        logic             wb_rdy;
        logic             dbg_rdy;
        logic             busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];
    logic [XLEN-1:0] shadow [NREGS];

    regfile_write_sched_if #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) bus ();

    regfile_write_sched #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .s_bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NREGS-1:0] we, input logic [XLEN-1:0] wd,
                        input logic wr, input logic dr, input logic busy);
        exp_t e;
        e.we = we; e.wdata = wd; e.wb_rdy = wr; e.dbg_rdy = dr; e.busy = busy;
        q.push_back(e);
    endtask

    // Monitor: any enable or ready is an output event; also models the
    // downstream register file, which captures at the coming posedge.
    initial begin
        exp_t act, e;
        for (int i = 0; i < NREGS; i++) shadow[i] = '0;
        forever begin
            @(negedge clk);
            act.we      = bus.rf_we;
            act.wdata   = bus.rf_wdata;
            act.wb_rdy  = bus.wb_ready;
            act.dbg_rdy = bus.dbg_ready;
            act.busy    = bus.init_busy;
            if (act.we != '0 || act.wb_rdy || act.dbg_rdy) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    e = q.pop_front();
                    check("write_event", 80'(act), 80'(e));
                end
                for (int i = 0; i < NREGS; i++)
                    if (act.we[i]) shadow[i] = act.wdata;
            end
        end
    end

    // Reset for one cycle, then expect n clear writes starting at x1.
    task automatic do_reset(input int n);
        reset = 1'b1;
        @(negedge clk);
        check("reset_forced", 80'({bus.rf_we, bus.rf_wdata, bus.wb_ready, bus.dbg_ready, bus.init_busy}),
              80'({{NREGS{1'b0}}, {XLEN{1'b0}}, 1'b0, 1'b0, 1'b1}));
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 1; i <= n; i++) push(NREGS'(1) << i, '0, 1'b0, 1'b0, 1'b1);
        repeat (n) cyc();
        if (n == NREGS - 1) begin
            bus.wb_valid  = 1'b0;
            bus.dbg_valid = 1'b0;
            @(negedge clk);
            check("run_idle", 80'({bus.init_busy, bus.rf_we}), 80'({1'b0, {NREGS{1'b0}}}));
            cyc();
        end
    endtask

    task automatic set_wb(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.wb_valid = v; bus.wb_addr = a; bus.wb_data = d;
    endtask

    task automatic set_dbg(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.dbg_valid = v; bus.dbg_addr = a; bus.dbg_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_wb(1'b0, '0, '0);
        set_dbg(1'b0, '0, '0);

        // 1: full clear walk after reset
        do_reset(NREGS - 1);

        // 2: single writeback
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        push(32'h20, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        cyc();
        set_wb(1'b0, '0, '0);
        cyc();
        n_cmp++;
        if (shadow[5] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL x5_value: got %h expected deadbeef", shadow[5]);
        end

        // 3: held contention alternates, wb first after reset
        do_reset(NREGS - 1);
        set_wb(1'b1, 5'd3, 32'hA);
        set_dbg(1'b1, 5'd4, 32'hB);
        push(32'h08, 32'hA, 1'b1, 1'b0, 1'b0);
        push(32'h10, 32'hB, 1'b0, 1'b1, 1'b0);
        push(32'h08, 32'hA, 1'b1, 1'b0, 1'b0);
        push(32'h10, 32'hB, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();
        set_wb(1'b0, '0, '0);
        set_dbg(1'b0, '0, '0);
        cyc();

        // 4: same-address collision, loser's data lands last
        do_reset(NREGS - 1);
        set_wb(1'b1, 5'd7, 32'h11);
        set_dbg(1'b1, 5'd7, 32'h22);
        push(32'h80, 32'h11, 1'b1, 1'b0, 1'b0);
        cyc();
        set_wb(1'b0, '0, '0);
        push(32'h80, 32'h22, 1'b0, 1'b1, 1'b0);
        cyc();
        set_dbg(1'b0, '0, '0);
        cyc();
        n_cmp++;
        if (shadow[7] !== 32'h22) begin
            n_err++;
            $display("FAIL x7_collision: got %h expected 00000022", shadow[7]);
        end

        // 5: write to x0 handshakes but enables nothing
        set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
        push('0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
        cyc();
        set_wb(1'b0, '0, '0);
        cyc();
        n_cmp++;
        if (shadow[0] !== 32'h0) begin
            n_err++;
            $display("FAIL x0_zero: got %h expected 00000000", shadow[0]);
        end

        // 6: reset mid-INIT, then reset over a pending RUN grant; requests
        // held through the restarted clear must see no ready
        do_reset(10);
        do_reset(NREGS - 1);
        set_wb(1'b1, 5'd9, 32'h55);
        set_dbg(1'b1, 5'd10, 32'h66);
        do_reset(NREGS - 1);
        set_wb(1'b1, 5'd2, 32'h12);
        set_dbg(1'b1, 5'd3, 32'h34);
        push(32'h04, 32'h12, 1'b1, 1'b0, 1'b0);
        cyc();
        set_wb(1'b0, '0, '0);
        push(32'h08, 32'h34, 1'b0, 1'b1, 1'b0);
        cyc();
        set_dbg(1'b0, '0, '0);
        repeat (3) cyc();

        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
